// File: rtl/dct_pkg.sv
// Q14 coefficient set shared by the 8-point forward and inverse DCT blocks.
package dct_pkg;
    localparam int COEF_W     = 16;
    localparam int COEF_FRAC  = 14;
    localparam int ROUND_BIAS = 8192;

    typedef logic signed [COEF_W-1:0] coef_t;

    localparam coef_t COEF_A = 16'sd5793;
    localparam coef_t COEF_B = 16'sd7568;
    localparam coef_t COEF_C = 16'sd3135;
    localparam coef_t COEF_D = 16'sd8035;
    localparam coef_t COEF_E = 16'sd6811;
    localparam coef_t COEF_F = 16'sd4551;
    localparam coef_t COEF_G = 16'sd1598;

    // Odd-part coefficient by column index: 0=D, 1=E, 2=F, 3=G.
    function automatic coef_t odd_coef(input int idx);
        coef_t c;
        case (idx)
            0:       c = COEF_D;
            1:       c = COEF_E;
            2:       c = COEF_F;
            default: c = COEF_G;
        endcase
        return c;
    endfunction
endpackage

// File: rtl/idct_round_sat.sv
// One output lane: Q14 round-half-up, arithmetic shift and clip to OUT_W bits.
module idct_round_sat
    import dct_pkg::*;
#(
    parameter int ACC_W = 26,
    parameter int OUT_W = 10
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [OUT_W-1:0] sample_o,
    output logic                    sat_o
);
    localparam logic signed [ACC_W:0] BIAS    = (ACC_W+1)'(ROUND_BIAS);
    localparam logic signed [ACC_W:0] MAX_VAL = (ACC_W+1)'((2 ** (OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0] MIN_VAL = (ACC_W+1)'(-(2 ** (OUT_W-1)));

    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] shifted;

    // One guard bit so adding the bias can never wrap.
    assign biased  = $signed({acc_i[ACC_W-1], acc_i}) + BIAS;
    assign shifted = biased >>> COEF_FRAC;

    always_comb begin
        sample_o = shifted[OUT_W-1:0];
        sat_o    = 1'b0;
        if (shifted > MAX_VAL) begin
            sample_o = MAX_VAL[OUT_W-1:0];
            sat_o    = 1'b1;
        end else if (shifted < MIN_VAL) begin
            sample_o = MIN_VAL[OUT_W-1:0];
            sat_o    = 1'b1;
        end
    end
endmodule

// File: rtl/idct_1d.sv
// 8-point 1-D inverse DCT, six register stages, full throughput, rounded and saturated output.
module idct_1d
    import dct_pkg::*;
#(
    parameter int IN_W  = 10,
    parameter int OUT_W = 10,
    parameter int ACC_W = 26
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  y0,
    input  logic signed [IN_W-1:0]  y1,
    input  logic signed [IN_W-1:0]  y2,
    input  logic signed [IN_W-1:0]  y3,
    input  logic signed [IN_W-1:0]  y4,
    input  logic signed [IN_W-1:0]  y5,
    input  logic signed [IN_W-1:0]  y6,
    input  logic signed [IN_W-1:0]  y7,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] x0,
    output logic signed [OUT_W-1:0] x1,
    output logic signed [OUT_W-1:0] x2,
    output logic signed [OUT_W-1:0] x3,
    output logic signed [OUT_W-1:0] x4,
    output logic signed [OUT_W-1:0] x5,
    output logic signed [OUT_W-1:0] x6,
    output logic signed [OUT_W-1:0] x7,
    output logic                    out_sat
);
    localparam int LANES = 8;
    localparam int DEPTH = 6;
    localparam int ODD_N = 4;

    typedef logic signed [ACC_W-1:0] acc_t;

    function automatic acc_t mul_c(input logic signed [IN_W-1:0] y, input coef_t c);
        acc_t y_ext;
        acc_t c_ext;
        y_ext = ACC_W'(y);
        c_ext = ACC_W'(c);
        return y_ext * c_ext;
    endfunction

    logic signed [IN_W-1:0]  y_in [LANES];

    logic [DEPTH-1:0]        vld_q;
    logic signed [IN_W-1:0]  y_q [LANES];
    acc_t                    ay0_q, ay4_q, by2_q, cy2_q, by6_q, cy6_q;
    acc_t                    odd_q [ODD_N][ODD_N];
    acc_t                    a0_q, a1_q, b0_q, b1_q;
    acc_t                    p_q [ODD_N][2];
    acc_t                    e_q [ODD_N];
    acc_t                    o_q [ODD_N];
    acc_t                    v_q [LANES];
    logic signed [OUT_W-1:0] x_q [LANES];
    logic                    sat_q;

    logic signed [OUT_W-1:0] r_d [LANES];
    logic [LANES-1:0]        clip_d;

    assign y_in[0] = y0;
    assign y_in[1] = y1;
    assign y_in[2] = y2;
    assign y_in[3] = y3;
    assign y_in[4] = y4;
    assign y_in[5] = y5;
    assign y_in[6] = y6;
    assign y_in[7] = y7;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            ay0_q <= '0;
            ay4_q <= '0;
            by2_q <= '0;
            cy2_q <= '0;
            by6_q <= '0;
            cy6_q <= '0;
            a0_q  <= '0;
            a1_q  <= '0;
            b0_q  <= '0;
            b1_q  <= '0;
            sat_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                y_q[i] <= '0;
                v_q[i] <= '0;
                x_q[i] <= '0;
            end
            for (int m = 0; m < ODD_N; m++) begin
                e_q[m]    <= '0;
                o_q[m]    <= '0;
                p_q[m][0] <= '0;
                p_q[m][1] <= '0;
                for (int c = 0; c < ODD_N; c++) begin
                    odd_q[m][c] <= '0;
                end
            end
        end else begin
            vld_q <= {vld_q[DEPTH-2:0], in_valid};

            for (int i = 0; i < LANES; i++) begin
                y_q[i] <= y_in[i];
            end

            ay0_q <= mul_c(y_q[0], COEF_A);
            ay4_q <= mul_c(y_q[4], COEF_A);
            by2_q <= mul_c(y_q[2], COEF_B);
            cy2_q <= mul_c(y_q[2], COEF_C);
            by6_q <= mul_c(y_q[6], COEF_B);
            cy6_q <= mul_c(y_q[6], COEF_C);
            // odd_q[m][c]: row m is y1/y3/y5/y7, column c is D/E/F/G.
            for (int m = 0; m < ODD_N; m++) begin
                for (int c = 0; c < ODD_N; c++) begin
                    odd_q[m][c] <= mul_c(y_q[2*m+1], odd_coef(c));
                end
            end

            a0_q <= ay0_q + ay4_q;
            a1_q <= ay0_q - ay4_q;
            b0_q <= by2_q + cy6_q;
            b1_q <= cy2_q - by6_q;
            p_q[0][0] <= odd_q[0][0] + odd_q[1][1];
            p_q[0][1] <= odd_q[2][2] + odd_q[3][3];
            p_q[1][0] <= odd_q[0][1] - odd_q[1][3];
            p_q[1][1] <= -odd_q[2][0] - odd_q[3][2];
            p_q[2][0] <= odd_q[0][2] - odd_q[1][0];
            p_q[2][1] <= odd_q[2][3] + odd_q[3][1];
            p_q[3][0] <= odd_q[0][3] - odd_q[1][2];
            p_q[3][1] <= odd_q[2][1] - odd_q[3][0];

            e_q[0] <= a0_q + b0_q;
            e_q[1] <= a1_q + b1_q;
            e_q[2] <= a1_q - b1_q;
            e_q[3] <= a0_q - b0_q;
            for (int m = 0; m < ODD_N; m++) begin
                o_q[m] <= p_q[m][0] + p_q[m][1];
            end

            for (int m = 0; m < ODD_N; m++) begin
                v_q[m]         <= e_q[m] + o_q[m];
                v_q[LANES-1-m] <= e_q[m] - o_q[m];
            end

            // Output registers only move when a real result arrives.
            if (vld_q[DEPTH-2]) begin
                x_q   <= r_d;
                sat_q <= |clip_d;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            idct_round_sat #(
                .ACC_W (ACC_W),
                .OUT_W (OUT_W)
            ) u_round_sat (
                .acc_i    (v_q[gi]),
                .sample_o (r_d[gi]),
                .sat_o    (clip_d[gi])
            );
        end
    endgenerate

    assign out_valid = vld_q[DEPTH-1];
    assign out_sat   = sat_q;
    assign x0 = x_q[0];
    assign x1 = x_q[1];
    assign x2 = x_q[2];
    assign x3 = x_q[3];
    assign x4 = x_q[4];
    assign x5 = x_q[5];
    assign x6 = x_q[6];
    assign x7 = x_q[7];
endmodule

// File: tb/tb_idct_1d.sv
// Scoreboard bench for idct_1d: stimulus pushes expected results, a monitor pops and compares.
module tb_idct_1d;
    localparam int A = 5793;
    localparam int B = 7568;
    localparam int C = 3135;
    localparam int D = 8035;
    localparam int E = 6811;
    localparam int F = 4551;
    localparam int G = 1598;

    // Reference inverse DCT matrix, row n = output sample, column k = coefficient.
    localparam int CM [8][8] = '{
        '{A,  D,  B,  E,  A,  F,  C,  G},
        '{A,  E,  C, -G, -A, -D, -B, -F},
        '{A,  F, -C, -D, -A,  G,  B,  E},
        '{A,  G, -B, -F,  A,  E, -C, -D},
        '{A, -G, -B,  F,  A, -E, -C,  D},
        '{A, -F, -C,  D, -A, -G,  B, -E},
        '{A, -E,  C,  G, -A,  D, -B,  F},
        '{A, -D,  B, -E,  A, -F,  C, -G}
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic signed [9:0] y0 = '0, y1 = '0, y2 = '0, y3 = '0, y4 = '0, y5 = '0, y6 = '0, y7 = '0;
    logic out_valid, out_sat;
    logic signed [9:0] x0, x1, x2, x3, x4, x5, x6, x7;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    logic [79:0] exp_x_q [$];
    bit          exp_s_q [$];
    int          exp_c_q [$];

    logic [79:0] last_x = '0;
    logic        last_s = 1'b0;

    idct_1d #(.IN_W(10), .OUT_W(10), .ACC_W(26)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .y0        (y0),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .y4        (y4),
        .y5        (y5),
        .y6        (y6),
        .y7        (y7),
        .out_valid (out_valid),
        .x0        (x0),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .x4        (x4),
        .x5        (x5),
        .x6        (x6),
        .x7        (x7),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [79:0] pk(input int a0, input int a1, input int a2, input int a3,
                                       input int a4, input int a5, input int a6, input int a7);
        return {10'(a7), 10'(a6), 10'(a5), 10'(a4), 10'(a3), 10'(a2), 10'(a1), 10'(a0)};
    endfunction

    function automatic string fmt(input logic [79:0] v);
        string s;
        logic signed [9:0] l;
        s = "";
        for (int i = 0; i < 8; i++) begin
            l = v[i*10 +: 10];
            s = {s, $sformatf(" %0d", l)};
        end
        return s;
    endfunction

    function automatic logic [80:0] model(input logic [79:0] yv);
        logic [80:0] r;
        logic signed [9:0] yl;
        int acc, q;
        r = '0;
        for (int n = 0; n < 8; n++) begin
            acc = 0;
            for (int k = 0; k < 8; k++) begin
                yl = yv[k*10 +: 10];
                acc += CM[n][k] * int'(yl);
            end
            q = (acc + 8192) >>> 14;
            if (q > 511) begin
                q = 511;
                r[80] = 1'b1;
            end else if (q < -512) begin
                q = -512;
                r[80] = 1'b1;
            end
            r[n*10 +: 10] = 10'(q);
        end
        return r;
    endfunction

    function automatic logic [79:0] dut_x();
        return {x7, x6, x5, x4, x3, x2, x1, x0};
    endfunction

    task automatic check_vec(input string name, input logic [79:0] got, input logic [79:0] req);
        n_checks++;
        if (got === req) n_pass++;
        else $display("FAIL %s: x got%s required%s", name, fmt(got), fmt(req));
    endtask

    task automatic check_int(input string name, input int got, input int req);
        n_checks++;
        if (got == req) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, got, req);
    endtask

    task automatic drive(input logic [79:0] yv);
        y0 = yv[9:0];   y1 = yv[19:10]; y2 = yv[29:20]; y3 = yv[39:30];
        y4 = yv[49:40]; y5 = yv[59:50]; y6 = yv[69:60]; y7 = yv[79:70];
    endtask

    task automatic send(input string tag, input logic [79:0] yv, input logic [79:0] xv, input bit sv);
        @(posedge clk); #1;
        in_valid = 1'b1;
        drive(yv);
        exp_x_q.push_back(xv);
        exp_s_q.push_back(sv);
        exp_c_q.push_back(cyc + 6);
        $display("send %-10s y:%s -> x:%s sat=%0d", tag, fmt(yv), fmt(xv), sv);
    endtask

    task automatic send_m(input string tag, input logic [79:0] yv);
        logic [80:0] r;
        r = model(yv);
        send(tag, yv, r[79:0], r[80]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            drive({$urandom, $urandom, $urandom});
        end
    endtask

    task automatic check_reset_state(input string name);
        @(negedge clk);
        check_int({name, "_valid"}, int'(out_valid), 0);
        check_int({name, "_sat"}, int'(out_sat), 0);
        check_vec({name, "_x"}, dut_x(), '0);
    endtask

    // Monitor: pop-and-compare on every valid output, hold check on every idle cycle.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            last_x = '0;
            last_s = 1'b0;
        end else if (out_valid === 1'b1) begin
            if (exp_x_q.size() == 0) begin
                check_int("unexpected_out_valid", 1, 0);
            end else begin
                logic [79:0] ex;
                bit es;
                int ec;
                ex = exp_x_q.pop_front();
                es = exp_s_q.pop_front();
                ec = exp_c_q.pop_front();
                check_vec("data", dut_x(), ex);
                check_int("sat", int'(out_sat), int'(es));
                check_int("latency_cycle", cyc, ec);
                $display("recv cyc=%0d x:%s sat=%0d", cyc, fmt(dut_x()), out_sat);
            end
            last_x = dut_x();
            last_s = out_sat;
        end else begin
            check_vec("hold_x", dut_x(), last_x);
            check_int("hold_sat", int'(out_sat), int'(last_s));
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_reset_state("reset");

        send("dc64", pk(64, 0, 0, 0, 0, 0, 0, 0), pk(23, 23, 23, 23, 23, 23, 23, 23), 1'b0);
        idle(7);
        send("dc283", pk(283, 0, 0, 0, 0, 0, 0, 0), pk(100, 100, 100, 100, 100, 100, 100, 100), 1'b0);
        send("dc-512", pk(-512, 0, 0, 0, 0, 0, 0, 0),
             pk(-181, -181, -181, -181, -181, -181, -181, -181), 1'b0);
        send("ac1", pk(0, 100, 0, 0, 0, 0, 0, 0), pk(49, 42, 28, 10, -10, -28, -42, -49), 1'b0);
        send("all511", pk(511, 511, 511, 511, 511, 511, 511, 511),
             pk(511, -368, 292, -103, 158, -15, 92, 40), 1'b1);
        send("dc64b", pk(64, 0, 0, 0, 0, 0, 0, 0), pk(23, 23, 23, 23, 23, 23, 23, 23), 1'b0);
        send_m("all-512", pk(-512, -512, -512, -512, -512, -512, -512, -512));
        idle(8);

        // Eight back-to-back vectors, two bubbles, then one more.
        send_m("t0", pk(100, 0, 0, 0, 0, 0, 0, 0));
        send_m("t1", pk(0, 0, 50, 0, 0, 0, 0, 0));
        send_m("t2", pk(0, 0, 0, -70, 0, 0, 0, 0));
        send_m("t3", pk(0, 0, 0, 0, 120, 0, 0, 0));
        send_m("t4", pk(0, 0, 0, 0, 0, 90, 0, 0));
        send_m("t5", pk(0, 0, 0, 0, 0, 0, -60, 0));
        send_m("t6", pk(0, 0, 0, 0, 0, 0, 0, 200));
        send_m("t7", pk(-300, 40, -20, 10, 5, -8, 3, -1));
        idle(2);
        send_m("t8", pk(511, -512, 300, -200, 100, -50, 25, -10));
        idle(9);

        // Three vectors in flight, then a one-cycle reset with a vector offered alongside it.
        send_m("lost0", pk(200, 0, 0, 0, 0, 0, 0, 0));
        send_m("lost1", pk(0, 300, 0, 0, 0, 0, 0, 0));
        send_m("lost2", pk(0, 0, 0, 0, 0, 0, 0, 400));
        @(posedge clk); #1;
        rst_n = 1'b0;
        in_valid = 1'b1;
        drive(pk(-400, 0, 0, 0, 0, 0, 0, 0));
        exp_x_q.delete();
        exp_s_q.delete();
        exp_c_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b0;
        check_reset_state("midreset");
        idle(3);
        send_m("post", pk(-100, 20, 30, -40, 50, -60, 70, -80));
        idle(1);

        for (int i = 0; i < 30 && exp_x_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check_int("drain_pending", exp_x_q.size(), 0);
        idle(10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
